// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the seven-segment character sequencer.
// Segment words are ordered g..a, so bit 0 drives segment a.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef logic [5:0] glyph_code_t;

    localparam int         GLYPH_COUNT = 42;
    localparam logic [6:0] SEG_UNDEF   = 7'b1000000;

    // 0-15 hex digits, then A b C c d E F g H h I i J L n O o P q r S t U u y degree
    localparam logic [6:0] GLYPH_TABLE [GLYPH_COUNT] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
        7'h77, 7'h7C, 7'h39, 7'h58, 7'h5E, 7'h79, 7'h71, 7'h6F,
        7'h76, 7'h74, 7'h30, 7'h10, 7'h1E, 7'h38, 7'h54, 7'h3F,
        7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C,
        7'h6E, 7'h63
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational glyph decoder: 6-bit code to g..a segment pattern.
// Codes outside the table show a single middle bar.
module seg7_decoder
    import seg7_pkg::*;
(
    input  glyph_code_t code_i,
    output logic [6:0]  seg_o
);

    always_comb begin
        seg_o = SEG_UNDEF;
        for (int i = 0; i < GLYPH_COUNT; i++) begin
            if (code_i == 6'(i)) begin
                seg_o = GLYPH_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/seg7_sequencer.sv
// Character FIFO feeding a seven-segment display: each code is shown for
// dwell+1 cycles, optionally followed by a blank gap, with a dot on the last one.
module seg7_sequencer
    import seg7_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                     clk_2,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [5:0]               wr_code,
    output logic                     wr_ready,
    input  logic [7:0]               dwell,
    input  logic                     blank_en,
    input  logic                     flush,
    output logic [7:0]               SEG,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [7:0]    GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_e          state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    glyph_code_t     cur_q, cur_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      seg_q, seg_d;
    logic            rdy_q;
    logic            push, pop;
    logic [6:0]      glyph_d;

    glyph_code_t     mem [DEPTH];

    seg7_decoder u_decoder (
        .code_i (cur_d),
        .seg_o  (glyph_d)
    );

    // rdy_q holds wr_ready low from reset until the first edge after release
    assign wr_ready = rdy_q && (count_q < FULL) && !flush;
    assign push     = wr_valid && wr_ready;
    assign busy     = (state_q != ST_IDLE);
    assign SEG      = seg_q;
    assign count    = count_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;

        if (flush) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: pop = (count_q != '0);
                ST_SHOW: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (blank_en) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (pop) begin
                cur_d    = mem[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
                cnt_d    = dwell;
                state_d  = ST_SHOW;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end

        seg_d = 8'h00;
        if (state_d == ST_SHOW) begin
            seg_d = {(count_d == '0), glyph_d};
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            seg_q    <= 8'h00;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            seg_q    <= seg_d;
            rdy_q    <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk_2) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_code;
        end
    end

endmodule

// File: tb/tb_seg7_sequencer.sv
// Self-checking bench for seg7_sequencer: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_seg7_sequencer;

    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int M_IDLE = 0, M_SHOW = 1, M_GAP = 2;

    localparam logic [6:0] REF_TABLE [42] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
        7'h77, 7'h7C, 7'h39, 7'h58, 7'h5E, 7'h79, 7'h71, 7'h6F,
        7'h76, 7'h74, 7'h30, 7'h10, 7'h1E, 7'h38, 7'h54, 7'h3F,
        7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C,
        7'h6E, 7'h63
    };

    logic       clk_2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [5:0] wr_code = '0;
    logic [7:0] dwell = '0;
    logic       blank_en = 1'b0;
    logic       flush = 1'b0;
    logic       wr_ready;
    logic [7:0] SEG;
    logic       busy;
    logic [3:0] count;

    always #5 clk_2 = ~clk_2;

    seg7_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk_2    (clk_2),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_code  (wr_code),
        .wr_ready (wr_ready),
        .dwell    (dwell),
        .blank_en (blank_en),
        .flush    (flush),
        .SEG      (SEG),
        .busy     (busy),
        .count    (count)
    );

    int q[$];
    int mode = M_IDLE;
    int left = 0;
    int cur  = 0;
    bit rdy_en = 1'b0;
    int checks = 0;
    int failures = 0;

    function automatic logic [6:0] ref_glyph(int c);
        return (c < 42) ? REF_TABLE[c] : 7'h40;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = M_IDLE;
        left = 0;
        rdy_en = 1'b0;
    endtask

    // Behavioural view: a queue of codes and a count of cycles left in the current phase
    task automatic model_edge();
        bit acc;
        bit start;
        acc = wr_valid && rdy_en && (q.size() < DEPTH) && !flush;
        start = 1'b0;
        if (flush) begin
            q.delete();
            mode = M_IDLE;
            left = 0;
        end else begin
            case (mode)
                M_IDLE: start = (q.size() > 0);
                M_SHOW: begin
                    if (left > 1) left--;
                    else if (blank_en) begin mode = M_GAP; left = GAP; end
                    else if (q.size() > 0) start = 1'b1;
                    else mode = M_IDLE;
                end
                default: begin
                    if (left > 1) left--;
                    else if (q.size() > 0) start = 1'b1;
                    else mode = M_IDLE;
                end
            endcase
            if (start) begin
                cur  = q.pop_front();
                left = int'(dwell) + 1;
                mode = M_SHOW;
            end
            if (acc) q.push_back(int'(wr_code));
        end
        rdy_en = 1'b1;
    endtask

    task automatic check_outputs();
        logic [7:0] exp_seg;
        exp_seg = (mode == M_SHOW) ? {(q.size() == 0), ref_glyph(cur)} : 8'h00;
        chk("seg", 32'(SEG), 32'(exp_seg));
        chk("busy", 32'(busy), 32'(mode != M_IDLE));
        chk("count", 32'(count), 32'(q.size()));
    endtask

    task automatic step(bit v, int c, int d, bit b, bit f);
        bit exp_rdy;
        @(negedge clk_2);
        wr_valid = v;
        wr_code  = 6'(c);
        dwell    = 8'(d);
        blank_en = b;
        flush    = f;
        exp_rdy  = rdy_en && (q.size() < DEPTH) && !f;
        #1 chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
        @(posedge clk_2);
        model_edge();
        #1 check_outputs();
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_seg"}, 32'(SEG), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_rdy"}, 32'(wr_ready), 32'h0);
    endtask

    // Assert reset between edges, check outputs clear at once, release after the next edge
    task automatic pulse_reset(string tag);
        @(negedge clk_2);
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        @(posedge clk_2);
        #2 rst_n = 1'b1;
    endtask

    logic [7:0] exp31 [11] = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7C,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'hB9};

    initial begin
        #1 check_all_zero("reset");
        @(posedge clk_2);
        #2 rst_n = 1'b1;
        model_reset();

        // Single code 0, dwell 2, no blanking
        step(0, 0, 2, 0, 0);
        step(1, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 2, 0, 0);
            chk("single_seg", 32'(SEG), (i < 3) ? 32'hBF : 32'h00);
        end
        chk("single_busy", 32'(busy), 32'h0);

        // Three codes with gaps, dot on the last
        step(1, 10, 0, 1, 0);
        step(1, 11, 0, 1, 0);
        chk("gap_seq0", 32'(SEG), 32'(exp31[0]));
        step(1, 12, 0, 1, 0);
        chk("gap_seq1", 32'(SEG), 32'(exp31[1]));
        for (int i = 2; i < 11; i++) begin
            step(0, 0, 0, 1, 0);
            chk("gap_seq", 32'(SEG), 32'(exp31[i]));
        end
        repeat (6) step(0, 0, 0, 1, 0);
        chk("gap_idle", 32'(busy), 32'h0);

        // Fill the FIFO behind a long first character, then drain in order
        for (int i = 0; i < 9; i++) step(1, 20 + i, 255, 0, 0);
        chk("full_count", 32'(count), 32'd8);
        chk("full_ready", 32'(wr_ready), 32'h0);
        repeat (260) step(1, 5, 0, 0, 0);
        repeat (15) step(0, 0, 0, 0, 0);

        // Flush mid-SHOW with a concurrent write
        step(1, 3, 5, 0, 0);
        step(1, 4, 5, 0, 0);
        step(0, 0, 5, 0, 0);
        step(1, 7, 5, 0, 1);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_seg", 32'(SEG), 32'h0);
        chk("flush_busy", 32'(busy), 32'h0);
        step(0, 0, 5, 0, 0);
        chk("flush_drop", 32'(count), 32'h0);

        // Undefined code, then reset pulsed during the gap
        step(1, 63, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        chk("undef_seg", 32'(SEG[6:0]), 32'h40);
        step(0, 0, 0, 1, 0);
        chk("in_gap", 32'(mode), 32'(M_GAP));
        pulse_reset("gap_reset");
        step(0, 0, 0, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 3) != 0, int'($urandom % 64), int'($urandom % 4),
                 bit'($urandom % 2), ($urandom % 40) == 0);
            if (i == 700) pulse_reset("rand_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_sequencer.md
SEG7_SEQUENCER -- requirements
Module: seg7_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning character FIFO entries (power of two).
REQ-002 SHALL have parameter GAP_CYCLES, default 4, meaning blank cycles inserted between characters when blank_en=1.
REQ-003 SHALL have port clk_2  input  1  meaning single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port wr_valid  input  1  meaning a character code is offered.
REQ-006 SHALL have port wr_code  input  6  meaning glyph code; 0-15 are hex digits, 16-41 are letters, 42-63 are undefined.
REQ-007 SHALL have port wr_ready  output  1  meaning the FIFO can accept a code this cycle.
REQ-008 SHALL have port dwell  input  8  meaning display cycles per character minus one, sampled at each pop.
REQ-009 SHALL have port blank_en  input  1  meaning insert a GAP state after each character, sampled at SHOW exit.
REQ-010 SHALL have port flush  input  1  meaning synchronous clear of FIFO and FSM.
REQ-011 SHALL have port SEG  output  8  meaning SEG[6:0] are glyph segments (g..a) and SEG[7] is the last-character dot.
REQ-012 SHALL have port busy  output  1  meaning the FSM is not in IDLE.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  meaning FIFO occupancy.

Function
REQ-014 SHALL accept a write on an edge where wr_valid=1 and wr_ready=1.
REQ-015 SHALL drive wr_ready = (count<DEPTH) and not flush.
  - No write-through when full, even if a pop occurs in the same cycle.
REQ-016 SHALL implement FSM states IDLE, SHOW and GAP.
  - IDLE/GAP-exit with count!=0: pop head into cur, load dwell counter with dwell, go to SHOW.
  - IDLE with count=0: stay in IDLE.
REQ-017 SHALL hold SHOW for exactly dwell+1 cycles; dwell=0 gives 1 cycle.
  - At expiry with blank_en=1: go to GAP for GAP_CYCLES cycles.
  - At expiry with blank_en=0: pop the next character immediately (back-to-back SHOW) if count!=0, else go to IDLE.
REQ-018 SHALL leave GAP to SHOW (pop) if count!=0, else to IDLE.
REQ-019 SHALL apply 1-cycle latency: a write on edge k into an empty FIFO while IDLE gives SHOW and a valid SEG after edge k+1.
REQ-020 SHALL leave count unchanged when a write and a pop occur on the same edge.
REQ-021 SHALL register SEG[6:0].
  - SHOW: decode(cur).
  - IDLE/GAP: 7'b0000000.
  - Codes 42-63 decode to 7'b1000000.
REQ-022 SHALL drive SEG[7]=1 only in SHOW while count=0 (the last queued character).
REQ-023 SHALL give flush priority over write and pop: next state IDLE, count=0, SEG=0 after the edge; a concurrent write is dropped.
REQ-024 SHALL use FIFO pointers that wrap modulo DEPTH; ordering is strictly FIFO.

Reset
REQ-025 SHALL on rst_n=0 immediately force state=IDLE, count=0, pointers=0, cur=0, dwell counter=0, SEG=8'h00, busy=0 and wr_ready=0.
  - wr_ready rises the first cycle after release.
REQ-026 SHALL discard any character or gap in progress on reset mid-operation.
REQ-027 SHALL not reset FIFO storage contents.

Structure
REQ-028 SHALL take the state enum, glyph code type (6 bits) and the 42-entry glyph table constants from the shared package seg7_pkg.
  - Table entries 0-15: hex 0-F.
  - Table entries 16-41: A b C c d E F g H h I i J L n O o P q r S t U u y degree.
REQ-029 SHALL instantiate one combinational sub-module seg7_decoder (6-bit code in, 7-bit segments out).

Verification
REQ-030 SHALL cover: reset release, write code 0 with dwell=2 and blank_en=0 -> SEG=8'b10111111 for exactly 3 cycles starting edge k+1, then 8'h00, busy=0.
REQ-031 SHALL cover: write codes 10, 11, 12 back-to-back, dwell=0, blank_en=1 -> SEG sequence 0x77, 4x00, 0x7C, 4x00, 0xB9 (dot set on last), then IDLE.
REQ-032 SHALL cover: 9 writes with SHOW stalled at dwell=255 -> count reaches 8 and wr_ready=0 at count 8 even on the pop edge; no code is lost and order is preserved.
REQ-033 SHALL cover: flush asserted mid-SHOW together with wr_valid -> count=0, SEG=0, busy=0 next cycle; the flushed-cycle write is absent.
REQ-034 SHALL cover: code 63 -> SEG[6:0]=7'b1000000; rst_n pulsed mid-GAP -> all outputs 0 asynchronously.
